decode_execute_reg: RTL and testbench

Decode→Execute pipeline register of the 5-stage RV32I core. It captures the main decoder's control outputs, the ALU control word, register-file read data, extended immediate, PC values and register indices at the end of Decode, and presents them to Execute one cycle later. It supports hazard-unit stall (hold) and flush (bubble insertion), and keeps a saturating count of bubbles inserted into Execute.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/decode_execute_reg_if.sv | 68 ++++++
 rtl/decode_execute_reg_pipe_reg.sv | 28 ++
 rtl/decode_execute_reg.sv | 80 ++++++++
 tb/tb_decode_execute_reg.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: result-mux encodings, opcodes, ALU control words,
// and the width helper for the Decode->Execute control bundle.
package riscv_pkg;

    localparam int RESULTW = 2;

    typedef enum logic [RESULTW-1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } resultSrc_e;

    // Major opcodes recognised by the main decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU control words produced by the ALU decoder
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Control bundle: Valid, RegWrite, ResultSrc, MemWrite, Branch, Jump,
    // ALUControl, ALUSrc, Funct3
    function automatic int ctrlWidth(input int aluW);
        return 1 + 1 + RESULTW + 1 + 1 + 1 + aluW + 1 + 3;
    endfunction

endpackage

// File: rtl/decode_execute_reg_if.sv
// Decode->Execute stage boundary: hazard controls, D-side inputs, E-side outputs.
interface decode_execute_reg_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int ALUCW = 3,
    parameter int CNTW  = 32
);
    logic                 StallE;
    logic                 FlushE;
    logic                 ValidD;
    logic                 RegWriteD;
    logic                 ALUSrcD;
    logic                 MemWriteD;
    logic                 BranchD;
    logic                 JumpD;
    logic [RESULTW-1:0]   ResultSrcD;
    logic [ALUCW-1:0]     ALUControlD;
    logic [2:0]           Funct3D;
    logic [XLEN-1:0]      RD1D;
    logic [XLEN-1:0]      RD2D;
    logic [XLEN-1:0]      ImmExtD;
    logic [XLEN-1:0]      PCD;
    logic [XLEN-1:0]      PCPlus4D;
    logic [REGW-1:0]      Rs1D;
    logic [REGW-1:0]      Rs2D;
    logic [REGW-1:0]      RdD;

    logic                 ValidE;
    logic                 RegWriteE;
    logic                 ALUSrcE;
    logic                 MemWriteE;
    logic                 BranchE;
    logic                 JumpE;
    logic [RESULTW-1:0]   ResultSrcE;
    logic [ALUCW-1:0]     ALUControlE;
    logic [2:0]           Funct3E;
    logic [XLEN-1:0]      RD1E;
    logic [XLEN-1:0]      RD2E;
    logic [XLEN-1:0]      ImmExtE;
    logic [XLEN-1:0]      PCE;
    logic [XLEN-1:0]      PCPlus4E;
    logic [REGW-1:0]      Rs1E;
    logic [REGW-1:0]      Rs2E;
    logic [REGW-1:0]      RdE;
    logic [CNTW-1:0]      BubbleCount;

    // Decode side / hazard unit drives the stage
    modport master (
        output StallE, FlushE, ValidD, RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD,
               ResultSrcD, ALUControlD, Funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
               Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, BubbleCount
    );

    // The pipeline register itself
    modport slave (
        input  StallE, FlushE, ValidD, RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD,
               ResultSrcD, ALUControlD, Funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
               Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, BubbleCount
    );
endinterface

// File: rtl/decode_execute_reg_pipe_reg.sv
// Generic pipeline register: sync reset, clear (bubble) beats enable (hold).
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic bitReg;

        // Per-bit flop: reset, then clear, then load when enabled, else hold
        always_ff @(posedge clk) begin
            if (rst) begin
                bitReg <= 1'b0;
            end else if (clr) begin
                bitReg <= 1'b0;
            end else if (en) begin
                bitReg <= d[gi];
            end
        end

        assign q[gi] = bitReg;
    end
endmodule

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with stall/flush and a saturating bubble counter.
// A bubble is all-zero, so ValidE=0 always comes with zero write/branch/jump controls
// and RdE=0 (never matches a forwarding source).
module decode_execute_reg
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int ALUCW = 3,
    parameter int CNTW  = 32
) (
    input logic clk,
    input logic rst,
    decode_execute_reg_if.slave bus
);
    localparam int CTRLW = ctrlWidth(ALUCW);
    localparam int DATAW = 5 * XLEN + 3 * REGW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [CTRLW-1:0] ctrlD;
    logic [CTRLW-1:0] ctrlE;
    logic [DATAW-1:0] dataD;
    logic [DATAW-1:0] dataE;
    logic             loadEn;
    logic             bubbleWrite;
    logic [CNTW-1:0]  bubbleCountReg;
    logic [CNTW-1:0]  bubbleCountNext;

    // Flush always bubbles; an invalid Decode slot bubbles only when actually loading
    assign loadEn      = ~bus.StallE;
    assign bubbleWrite = bus.FlushE | (~bus.StallE & ~bus.ValidD);

    assign ctrlD = {bus.ValidD, bus.RegWriteD, bus.ResultSrcD, bus.MemWriteD, bus.BranchD,
                    bus.JumpD, bus.ALUControlD, bus.ALUSrcD, bus.Funct3D};
    assign dataD = {bus.RD1D, bus.RD2D, bus.ImmExtD, bus.PCD, bus.PCPlus4D,
                    bus.Rs1D, bus.Rs2D, bus.RdD};

    pipe_reg #(.W(CTRLW)) ctrlStage (
        .clk (clk),
        .rst (rst),
        .en  (loadEn),
        .clr (bubbleWrite),
        .d   (ctrlD),
        .q   (ctrlE)
    );

    pipe_reg #(.W(DATAW)) dataStage (
        .clk (clk),
        .rst (rst),
        .en  (loadEn),
        .clr (bubbleWrite),
        .d   (dataD),
        .q   (dataE)
    );

    assign {bus.ValidE, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.BranchE,
            bus.JumpE, bus.ALUControlE, bus.ALUSrcE, bus.Funct3E} = ctrlE;
    assign {bus.RD1E, bus.RD2E, bus.ImmExtE, bus.PCE, bus.PCPlus4E,
            bus.Rs1E, bus.Rs2E, bus.RdE} = dataE;

    // Count each bubble written, sticking at all-ones
    always_comb begin
        bubbleCountNext = bubbleCountReg;
        if (bubbleWrite && (bubbleCountReg != CNT_MAX)) begin
            bubbleCountNext = bubbleCountReg + CNT_ONE;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            bubbleCountReg <= '0;
        end else begin
            bubbleCountReg <= bubbleCountNext;
        end
    end

    assign bus.BubbleCount = bubbleCountReg;
endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed + randomized bench for decode_execute_reg (main instance and a CNTW=4 instance).
module tb_decode_execute_reg;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic        memWrite;
        logic        branch;
        logic        jump;
        logic [2:0]  aluControl;
        logic        aluSrc;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rstS = 1'b1;
    int   vecCount = 0;
    int   missCount = 0;

    always #5 clk = ~clk;

    decode_execute_reg_if #(.XLEN(32), .REGW(5), .ALUCW(3), .CNTW(32)) busA ();
    decode_execute_reg_if #(.XLEN(32), .REGW(5), .ALUCW(3), .CNTW(4))  busS ();

    decode_execute_reg #(.XLEN(32), .REGW(5), .ALUCW(3), .CNTW(32)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    decode_execute_reg #(.XLEN(32), .REGW(5), .ALUCW(3), .CNTW(4)) dutS (
        .clk (clk),
        .rst (rstS),
        .bus (busS)
    );

    task automatic checkVal(input string tag, input logic [191:0] got, input logic [191:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveD(input stage_t v);
        busA.ValidD      = v.valid;
        busA.RegWriteD   = v.regWrite;
        busA.ResultSrcD  = v.resultSrc;
        busA.MemWriteD   = v.memWrite;
        busA.BranchD     = v.branch;
        busA.JumpD       = v.jump;
        busA.ALUControlD = v.aluControl;
        busA.ALUSrcD     = v.aluSrc;
        busA.Funct3D     = v.funct3;
        busA.RD1D        = v.rd1;
        busA.RD2D        = v.rd2;
        busA.ImmExtD     = v.imm;
        busA.PCD         = v.pc;
        busA.PCPlus4D    = v.pcPlus4;
        busA.Rs1D        = v.rs1;
        busA.Rs2D        = v.rs2;
        busA.RdD         = v.rd;
    endtask

    function automatic stage_t readE();
        stage_t e;
        e.valid      = busA.ValidE;
        e.regWrite   = busA.RegWriteE;
        e.resultSrc  = busA.ResultSrcE;
        e.memWrite   = busA.MemWriteE;
        e.branch     = busA.BranchE;
        e.jump       = busA.JumpE;
        e.aluControl = busA.ALUControlE;
        e.aluSrc     = busA.ALUSrcE;
        e.funct3     = busA.Funct3E;
        e.rd1        = busA.RD1E;
        e.rd2        = busA.RD2E;
        e.imm        = busA.ImmExtE;
        e.pc         = busA.PCE;
        e.pcPlus4    = busA.PCPlus4E;
        e.rs1        = busA.Rs1E;
        e.rs2        = busA.Rs2E;
        e.rd         = busA.RdE;
        return e;
    endfunction

    function automatic stage_t randVec(input logic valid);
        stage_t v;
        v.valid      = valid;
        v.regWrite   = 1'($urandom_range(0, 1));
        v.resultSrc  = 2'($urandom_range(0, 2));
        v.memWrite   = 1'($urandom_range(0, 1));
        v.branch     = 1'($urandom_range(0, 1));
        v.jump       = 1'($urandom_range(0, 1));
        v.aluControl = 3'($urandom_range(0, 7));
        v.aluSrc     = 1'($urandom_range(0, 1));
        v.funct3     = 3'($urandom_range(0, 7));
        v.rd1        = $urandom;
        v.rd2        = $urandom;
        v.imm        = $urandom;
        v.pc         = $urandom;
        v.pcPlus4    = $urandom;
        v.rs1        = 5'($urandom_range(0, 31));
        v.rs2        = 5'($urandom_range(0, 31));
        v.rd         = 5'($urandom_range(0, 31));
        return v;
    endfunction

    // Fully nonzero vector with explicit fields
    function automatic stage_t mkVec(input logic [31:0] seed, input logic [4:0] rd);
        stage_t v;
        v.valid      = 1'b1;
        v.regWrite   = 1'b1;
        v.resultSrc  = 2'b01;
        v.memWrite   = 1'b1;
        v.branch     = 1'b1;
        v.jump       = 1'b1;
        v.aluControl = 3'b101;
        v.aluSrc     = 1'b1;
        v.funct3     = 3'b010;
        v.rd1        = seed;
        v.rd2        = seed ^ 32'hFFFF_0000;
        v.imm        = seed + 32'd4;
        v.pc         = 32'h0000_1000 + seed[7:0];
        v.pcPlus4    = 32'h0000_1004 + seed[7:0];
        v.rs1        = 5'd3;
        v.rs2        = 5'd9;
        v.rd         = rd;
        return v;
    endfunction

    initial begin
        stage_t v1, v2, v3, vN, expE;
        logic [31:0] expCnt;
        logic stall, flush;

        busA.StallE = 1'b0;
        busA.FlushE = 1'b0;
        driveD(mkVec(32'hDEAD_BEEF, 5'd31));
        busS.StallE = 1'b0; busS.FlushE = 1'b0; busS.ValidD = 1'b0;
        busS.RegWriteD = 1'b0; busS.ALUSrcD = 1'b0; busS.MemWriteD = 1'b0;
        busS.BranchD = 1'b0; busS.JumpD = 1'b0; busS.ResultSrcD = 2'b00;
        busS.ALUControlD = 3'b000; busS.Funct3D = 3'b000;
        busS.RD1D = '0; busS.RD2D = '0; busS.ImmExtD = '0; busS.PCD = '0; busS.PCPlus4D = '0;
        busS.Rs1D = '0; busS.Rs2D = '0; busS.RdD = '0;

        // Reset with nonzero D inputs held for 2 cycles
        rst = 1'b1;
        step();
        step();
        checkVal("reset_E", readE(), '0);
        checkVal("reset_cnt", busA.BubbleCount, 0);
        checkVal("reset_valid", busA.ValidE, 0);
        rst = 1'b0;

        // Normal flow
        v1 = mkVec(32'h1234_5678, 5'd7);
        v1.memWrite = 1'b0;
        v1.branch = 1'b0;
        v1.jump = 1'b0;
        driveD(v1);
        step();
        checkVal("load_E", readE(), v1);
        checkVal("load_RegWriteE", busA.RegWriteE, 1);
        checkVal("load_RD1E", busA.RD1E, 32'h1234_5678);
        checkVal("load_RdE", busA.RdE, 7);
        checkVal("load_cnt", busA.BubbleCount, 0);

        // Stall: hold v2 for 3 cycles while D changes (including an invalid slot)
        v2 = mkVec(32'hA5A5_0001, 5'd12);
        driveD(v2);
        step();
        checkVal("stall_pre", readE(), v2);
        busA.StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vN = randVec(i != 1);
            driveD(vN);
            step();
            checkVal($sformatf("stall_hold%0d", i), readE(), v2);
            checkVal($sformatf("stall_cnt%0d", i), busA.BubbleCount, 0);
        end
        busA.StallE = 1'b0;
        v3 = mkVec(32'h0BAD_F00D, 5'd21);
        driveD(v3);
        step();
        checkVal("stall_release", readE(), v3);

        // Flush together with stall, MemWriteD=1
        busA.StallE = 1'b1;
        busA.FlushE = 1'b1;
        vN = mkVec(32'h7777_7777, 5'd5);
        driveD(vN);
        step();
        checkVal("flush_E", readE(), '0);
        checkVal("flush_MemWriteE", busA.MemWriteE, 0);
        checkVal("flush_RdE", busA.RdE, 0);
        checkVal("flush_cnt", busA.BubbleCount, 1);
        busA.StallE = 1'b0;
        busA.FlushE = 1'b0;

        // Bubble via ValidD=0 with Branch/Jump set
        vN = mkVec(32'h3333_0000, 5'd9);
        vN.valid = 1'b0;
        driveD(vN);
        step();
        checkVal("bubble_E", readE(), '0);
        checkVal("bubble_BJ", {busA.BranchE, busA.JumpE}, 0);
        checkVal("bubble_cnt", busA.BubbleCount, 2);

        // Reset while stalled clears everything; next edge is a normal load
        driveD(v3);
        step();
        checkVal("preRst_E", readE(), v3);
        busA.StallE = 1'b1;
        rst = 1'b1;
        step();
        checkVal("rstStall_E", readE(), '0);
        checkVal("rstStall_cnt", busA.BubbleCount, 0);
        rst = 1'b0;
        busA.StallE = 1'b0;
        driveD(v1);
        step();
        checkVal("postRst_E", readE(), v1);

        // Random stimulus against a behavioural model
        expE = v1;
        expCnt = 0;
        for (int i = 0; i < 10000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            vN = randVec($urandom_range(0, 9) < 7);
            busA.StallE = stall;
            busA.FlushE = flush;
            driveD(vN);
            if (flush || (!stall && !vN.valid)) begin
                expE = '0;
                expCnt = expCnt + 32'd1;
            end else if (!stall) begin
                expE = vN;
            end
            step();
            checkVal("rand_E", readE(), expE);
            checkVal("rand_cnt", busA.BubbleCount, expCnt);
            if (!busA.ValidE) begin
                checkVal("rand_inv", {busA.RegWriteE, busA.MemWriteE, busA.BranchE, busA.JumpE}, 0);
            end
        end
        busA.StallE = 1'b0;
        busA.FlushE = 1'b0;

        // Saturation on the 4-bit counter instance
        checkVal("sat_reset", busS.BubbleCount, 0);
        rstS = 1'b0;
        busS.FlushE = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checkVal($sformatf("sat_%0d", i), busS.BubbleCount, (i > 15) ? 15 : i);
        end
        rstS = 1'b1;
        step();
        checkVal("sat_rst", busS.BubbleCount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
